// File: rtl/line_memory_pkg.sv
// Shared constants and types for the line-granular memory responder.
// A line is four 16-bit words; word 0 sits in the top bits of the line bus.
package line_memory_pkg;

    localparam int WORD_SIZE         = 16;
    localparam int LINE_WIDTH        = 4 * WORD_SIZE;
    localparam int DEFAULT_LATENCY   = 4;
    localparam int DEFAULT_MEM_LINES = 16384;
    localparam int LAT_CNT_W         = 3;

    typedef enum logic [1:0] {
        MEM_IDLE    = 2'd0,
        MEM_ACCESS  = 2'd1,
        MEM_RESPOND = 2'd2
    } mem_state_t;

    typedef enum logic {
        OP_READ  = 1'b0,
        OP_WRITE = 1'b1
    } mem_op_t;

endpackage

// File: rtl/line_memory_latency_counter.sv
// Down-counter that times the ACCESS phase. Loaded on request acceptance;
// 'expired' is high during the last ACCESS cycle so the FSM moves to
// RESPOND on the following edge (LATENCY-1 ACCESS cycles in total).
module mem_latency_counter
    import line_memory_pkg::*;
#(
    parameter int LATENCY = DEFAULT_LATENCY
) (
    input  logic clk,
    input  logic reset_n,
    input  logic load,
    output logic expired
);

    logic [LAT_CNT_W-1:0] count;

    // Load on acceptance, then count down to zero and hold there.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count <= '0;
        end else if (load) begin
            count <= LAT_CNT_W'(LATENCY - 2);
        end else if (count != '0) begin
            count <= count - 1'b1;
        end
    end

    assign expired = (count == '0);

endmodule

// File: rtl/line_memory.sv
// Line-granular main-memory responder on the cache-to-memory interface.
// Accepts one 4-word line read or write, completes it after LATENCY cycles
// with a one-cycle mem_ready pulse, and drives read data during that pulse.
// Optional macro LINE_MEMORY_STATS_EN adds saturating read/write counters.
module line_memory
    import line_memory_pkg::*;
#(
    parameter int LATENCY   = DEFAULT_LATENCY,
    parameter int MEM_LINES = DEFAULT_MEM_LINES
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  readM,
    input  logic                  writeM,
    input  logic [15:0]           address_memory,
    inout  wire  [LINE_WIDTH-1:0] data_mem_cache,
    output logic                  mem_ready,
    output logic                  mem_busy,
    output logic                  mem_error
`ifdef LINE_MEMORY_STATS_EN
    ,
    output logic [15:0]           num_mem_read,
    output logic [15:0]           num_mem_write
`endif
);

    localparam int IDX_W = (MEM_LINES > 1) ? $clog2(MEM_LINES) : 1;

    mem_state_t            state;
    mem_state_t            next_state;
    mem_op_t               op_q;
    logic [13:0]           line_q;
    logic [LINE_WIDTH-1:0] wdata_q;
    logic [LINE_WIDTH-1:0] rdata_q;
    logic [IDX_W-1:0]      line_index;
    logic                  armed;
    logic                  accept;
    logic                  error_seen;
    logic                  enter_respond;
    logic                  expired;
    logic                  drive_bus;
    logic                  unused_addr_bits;

    logic [LINE_WIDTH-1:0] mem_array [MEM_LINES];

    assign unused_addr_bits = ^address_memory[1:0];
    assign line_index       = IDX_W'(32'(line_q) % MEM_LINES);

    mem_latency_counter #(
        .LATENCY (LATENCY)
    ) u_latency (
        .clk     (clk),
        .reset_n (reset_n),
        .load    (accept),
        .expired (expired)
    );

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= MEM_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic and per-cycle control strobes.
    always_comb begin
        next_state    = state;
        accept        = 1'b0;
        error_seen    = 1'b0;
        enter_respond = 1'b0;
        case (state)
            MEM_IDLE: begin
                if (readM && writeM) begin
                    error_seen = 1'b1;
                end else if ((readM ^ writeM) && armed) begin
                    accept     = 1'b1;
                    next_state = MEM_ACCESS;
                end
            end
            MEM_ACCESS: begin
                if (expired) begin
                    enter_respond = 1'b1;
                    next_state    = MEM_RESPOND;
                end
            end
            MEM_RESPOND: begin
                next_state = MEM_IDLE;
            end
            default: begin
                next_state = MEM_IDLE;
            end
        endcase
    end

    // Re-arm flag: a level-held request must drop before it can be served again.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            armed <= 1'b1;
        end else if (!(readM || writeM)) begin
            armed <= 1'b1;
        end else if (state == MEM_RESPOND) begin
            armed <= 1'b0;
        end
    end

    // Capture operation, line address and write data at acceptance.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            op_q    <= OP_READ;
            line_q  <= '0;
            wdata_q <= '0;
        end else if (accept) begin
            op_q   <= writeM ? OP_WRITE : OP_READ;
            line_q <= address_memory[15:2];
            if (writeM) begin
                wdata_q <= data_mem_cache;
            end
        end
    end

    // Array access on RESPOND entry; the array itself is never reset.
    always_ff @(posedge clk) begin
        if (enter_respond) begin
            if (op_q == OP_WRITE) begin
                mem_array[line_index] <= wdata_q;
            end else begin
                rdata_q <= mem_array[line_index];
            end
        end
    end

    // One-cycle error pulse after a simultaneous read and write request in IDLE.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mem_error <= 1'b0;
        end else begin
            mem_error <= error_seen;
        end
    end

`ifdef LINE_MEMORY_STATS_EN
    // Saturating counts of accepted reads and writes.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            num_mem_read  <= '0;
            num_mem_write <= '0;
        end else if (accept) begin
            if (writeM && num_mem_write != 16'hFFFF) begin
                num_mem_write <= num_mem_write + 16'd1;
            end else if (!writeM && num_mem_read != 16'hFFFF) begin
                num_mem_read <= num_mem_read + 16'd1;
            end
        end
    end
`endif

    assign mem_ready      = (state == MEM_RESPOND);
    assign mem_busy       = (state != MEM_IDLE);
    assign drive_bus      = mem_ready && (op_q == OP_READ);
    assign data_mem_cache = drive_bus ? rdata_q : {LINE_WIDTH{1'bz}};

endmodule
